// File: rtl/pow3_pkg.sv
// Shared definitions for the power-of-3 sequencer: FSM state codes, default
// widths and the overflow threshold helper.
package pow3_pkg;

    localparam int unsigned CNT_W_DEFAULT = 6;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CLEAR = 2'd1;
    localparam state_t ST_EMIT  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Largest value that can still be multiplied by 3 without exceeding w bits.
    function automatic logic [63:0] max3(input int unsigned w);
        logic [63:0] all_ones;
        all_ones = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return all_ones / 64'd3;
    endfunction

endpackage

// File: rtl/pow3_seq_ctrl.sv
// Sequencer for the power-of-3 generator: accepts "emit 3^0..3^N", clears the
// generator, streams one value per accepted beat and stops early on overflow.
module pow3_seq_ctrl
    import pow3_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic              gen_rst,
    output logic              gen_enable,
    input  logic [DATA_W-1:0] gen_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_index,
    output logic              out_last,
    output logic              done,
    output logic              done_ovf
);

    localparam logic [DATA_W-1:0] MAX3 = DATA_W'(max3(DATA_W));

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             ovf_q, ovf_d;

    logic in_emit;
    logic at_n;
    logic ovf_next;
    logic last;

    assign in_emit  = (state_q == ST_EMIT);
    assign at_n     = (idx_q == n_q);
    // Multiplying anything above MAX3 by 3 would not fit in DATA_W bits.
    assign ovf_next = (gen_value > MAX3);
    assign last     = at_n | ovf_next;

    // Next-state logic for the FSM, exponent counter and overflow flag.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    n_d     = cmd_count;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (last) begin
                        // Reaching N takes precedence: only a cut-short run is flagged.
                        ovf_d   = ovf_next & ~at_n;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            ovf_q   <= ovf_d;
        end
    end

    // Output decode; gen_enable steps the generator in the same cycle as the handshake.
    always_comb begin
        cmd_ready  = rst & (state_q == ST_IDLE);
        gen_rst    = (state_q == ST_CLEAR);
        gen_enable = in_emit & out_ready & ~last;
        out_valid  = in_emit;
        out_data   = gen_value;
        out_index  = idx_q;
        out_last   = in_emit & last;
        done       = (state_q == ST_DONE);
        done_ovf   = (state_q == ST_DONE) & ovf_q;
    end

endmodule

// File: tb/tb_pow3_seq_ctrl.sv
// Bench for pow3_seq_ctrl: a 32-bit and an 8-bit controller, each paired with
// a behavioural generator, driven by the same command and ready stimulus.
module tb_pow3_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [5:0] cmd_count;
    logic       out_ready;

    logic [31:0] gen32;
    logic [7:0]  gen8;
    wire  [31:0] od32;
    wire  [7:0]  od8;
    wire  [5:0]  oi0, oi1;
    wire  [1:0]  cr, gr, ge, ov, ol, dn, dv;

    logic [31:0] od [2];
    logic [5:0]  oi [2];
    assign od[0] = od32;
    assign od[1] = {24'd0, od8};
    assign oi[0] = oi0;
    assign oi[1] = oi1;

    int n_checks = 0;
    int n_fail   = 0;
    int wd [2]   = '{32, 8};
    int mx [2];

    always #5 clk = ~clk;

    pow3_seq_ctrl #(.DATA_W(32), .CNT_W(6)) u_dut32 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cr[0]),
        .cmd_count(cmd_count), .gen_rst(gr[0]), .gen_enable(ge[0]), .gen_value(gen32),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od32), .out_index(oi0),
        .out_last(ol[0]), .done(dn[0]), .done_ovf(dv[0])
    );

    pow3_seq_ctrl #(.DATA_W(8), .CNT_W(6)) u_dut8 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cr[1]),
        .cmd_count(cmd_count), .gen_rst(gr[1]), .gen_enable(ge[1]), .gen_value(gen8),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od8), .out_index(oi1),
        .out_last(ol[1]), .done(dn[1]), .done_ovf(dv[1])
    );

    // Behavioural generators: clear loads 1, enable multiplies by 3.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       gen32 <= '0;
        else if (gr[0]) gen32 <= 32'd1;
        else if (ge[0]) gen32 <= gen32 * 32'd3;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       gen8 <= '0;
        else if (gr[1]) gen8 <= 8'd1;
        else if (ge[1]) gen8 <= gen8 * 8'd3;
    end

    function automatic longint unsigned p3(input int k);
        longint unsigned v = 1;
        for (int j = 0; j < k; j++) v = v * 3;
        return v;
    endfunction

    // Highest exponent e with 3^e representable in w bits.
    function automatic int max_exp(input int w);
        longint unsigned lim = (64'd1 << w) - 64'd1;
        longint unsigned v = 1;
        int e = 0;
        while (v * 3 <= lim) begin
            v = v * 3;
            e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cmd_valid = 1'($urandom);
            cmd_count = 6'($urandom);
            out_ready = 1'($urandom);
            #1;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({cr[i], gr[i], ge[i], ov[i], ol[i], dn[i], dv[i]} !== 7'd0) begin
                    n_fail++;
                    $display("FAIL reset_outputs inst%0d: got %b want 0000000", i,
                             {cr[i], gr[i], ge[i], ov[i], ol[i], dn[i], dv[i]});
                end
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({cr[i], gr[i], ov[i]} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_release inst%0d: got rdy/clr/vld %b want 100", i,
                         {cr[i], gr[i], ov[i]});
            end
        end
    endtask

    // One command on both controllers. mode 0: always ready, 1: pattern, 2: random.
    // abort_at >= 0 pulls reset while the 32-bit instance shows that index.
    task automatic run_seq(input string name, input int n, input int mode, input int abort_at);
        int          k [2];
        int          beats [2];
        bit          eovf [2];
        bit          fin [2];
        bit          pstall [2];
        logic [31:0] pdat [2];
        logic [5:0]  pidx [2];
        bit          pat [6] = '{1, 0, 0, 1, 0, 1};
        bit          stop;
        bit          ev;
        bit          el;
        int          cyc;
        logic        rdy;

        stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            k[i]      = 0;
            beats[i]  = ((n < mx[i]) ? n : mx[i]) + 1;
            eovf[i]   = (n > mx[i]);
            fin[i]    = 1'b0;
            pstall[i] = 1'b0;
            pdat[i]   = '0;
            pidx[i]   = '0;
        end

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_count = 6'(n);
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (cr[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL %s cmd_ready inst%0d: got %b want 1", name, i, cr[i]);
            end
        end

        cyc = 0;
        while (!stop && !(fin[0] && fin[1]) && cyc < 300) begin
            cyc++;
            @(negedge clk);
            if (!fin[0] && !fin[1]) begin
                cmd_valid = 1'($urandom);
                cmd_count = 6'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (cyc >= 2) ? pat[(cyc - 2) % 6] : 1'b0;
            else                rdy = 1'($urandom);
            out_ready = rdy;
            #1;
            for (int i = 0; i < 2; i++) begin
                if (fin[i]) begin
                    n_checks++;
                    if ({cr[i], dn[i], ge[i], ov[i]} !== 4'b1000) begin
                        n_fail++;
                        $display("FAIL %s after_done inst%0d: got rdy/done/en/vld %b want 1000",
                                 name, i, {cr[i], dn[i], ge[i], ov[i]});
                    end
                    continue;
                end
                ev = (cyc >= 2) && (k[i] < beats[i]);
                el = (k[i] == beats[i] - 1);
                n_checks++;
                if (gr[i] !== (cyc == 1)) begin
                    n_fail++;
                    $display("FAIL %s gen_rst inst%0d cyc%0d: got %b want %b", name, i, cyc,
                             gr[i], (cyc == 1));
                end
                n_checks++;
                if (cr[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s busy_ready inst%0d cyc%0d: got %b want 0", name, i, cyc,
                             cr[i]);
                end
                n_checks++;
                if (ov[i] !== ev) begin
                    n_fail++;
                    $display("FAIL %s out_valid inst%0d cyc%0d: got %b want %b", name, i, cyc,
                             ov[i], ev);
                end
                n_checks++;
                if (ge[i] !== (ev && rdy && !el)) begin
                    n_fail++;
                    $display("FAIL %s gen_enable inst%0d cyc%0d: got %b want %b", name, i, cyc,
                             ge[i], (ev && rdy && !el));
                end
                n_checks++;
                if (dn[i] !== (k[i] == beats[i])) begin
                    n_fail++;
                    $display("FAIL %s done inst%0d cyc%0d: got %b want %b", name, i, cyc,
                             dn[i], (k[i] == beats[i]));
                end
                if (ev) begin
                    n_checks++;
                    if (od[i] !== 32'(p3(k[i])) || oi[i] !== 6'(k[i]) || ol[i] !== el) begin
                        n_fail++;
                        $display("FAIL %s beat inst%0d: got data %0d idx %0d last %b want %0d %0d %b",
                                 name, i, od[i], oi[i], ol[i], p3(k[i]), k[i], el);
                    end
                    if (pstall[i]) begin
                        n_checks++;
                        if (od[i] !== pdat[i] || oi[i] !== pidx[i]) begin
                            n_fail++;
                            $display("FAIL %s stall_stable inst%0d: got %0d/%0d want %0d/%0d",
                                     name, i, od[i], oi[i], pdat[i], pidx[i]);
                        end
                    end
                    if (i == 0 && k[i] == abort_at) stop = 1'b1;
                end
                if (k[i] == beats[i]) begin
                    n_checks++;
                    if (dv[i] !== eovf[i]) begin
                        n_fail++;
                        $display("FAIL %s done_ovf inst%0d: got %b want %b", name, i, dv[i],
                                 eovf[i]);
                    end
                    fin[i] = 1'b1;
                end
                pstall[i] = ev && !rdy;
                pdat[i]   = od[i];
                pidx[i]   = oi[i];
                if (ev && rdy) k[i]++;
            end
        end
        cmd_valid = 1'b0;

        if (stop) begin
            rst = 1'b0;
            #1;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({ov[i], dn[i], cr[i]} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL %s mid_reset inst%0d: got vld/done/rdy %b want 000", name, i,
                             {ov[i], dn[i], cr[i]});
                end
            end
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                #1;
                n_checks++;
                if (dn !== 2'b00) begin
                    n_fail++;
                    $display("FAIL %s no_done_in_reset: got %b want 00", name, dn);
                end
            end
            @(negedge clk);
            rst = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!fin[i]) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s timeout inst%0d: got %0d beats want %0d plus done", name,
                             i, k[i], beats[i]);
                end
            end
        end
    endtask

    task automatic test_basic();
        run_seq("basic_n3", 3, 0, -1);
    endtask

    task automatic test_backpressure();
        run_seq("bp_n4", 4, 1, -1);
    endtask

    task automatic test_overflow();
        run_seq("ovf_n10", 10, 0, -1);
        run_seq("ovf_n10_bp", 10, 1, -1);
    endtask

    task automatic test_boundaries();
        run_seq("exact_n5", 5, 0, -1);
        run_seq("exact_n20", 20, 2, -1);
        run_seq("beyond_n21", 21, 0, -1);
        run_seq("zero_n0", 0, 0, -1);
        run_seq("max_n63", 63, 2, -1);
    endtask

    task automatic test_reset_mid();
        run_seq("mid_n4", 4, 0, 2);
        run_seq("after_rst_n1", 1, 0, -1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) run_seq("random", $urandom_range(0, 63), 2, -1);
    endtask

    task automatic test_back_to_back();
        run_seq("b2b_a", 2, 0, -1);
        run_seq("b2b_b", 0, 0, -1);
        run_seq("b2b_c", 7, 1, -1);
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_count = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) mx[i] = max_exp(wd[i]);
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_boundaries();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
